// File: rtl/arb_pkg.sv
// Shared constants, state type and small helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Rotate left within 8 bits: bit i moves to position (i + amt) mod 8.
  function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] vec,
                                             input logic [IDX_W-1:0] amt);
    logic [2*N_REQ-1:0] dbl;
    dbl = {vec, vec} << amt;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder; the highest set bit wins.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Highest-index-first priority decode.
  always_comb begin
    idx = 3'd0;
    any = 1'b1;
    priority casez (vec)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default: begin
        idx = 3'd0;
        any = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with grant hold, hold-time timeout and a
// guaranteed one-cycle turnaround gap between owners. All outputs are registered.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C  = CNT_W'(MAX_HOLD);
  localparam logic             TIMEOUT_EN  = (MAX_HOLD != 32'd0);
  localparam logic [CNT_W-1:0] CNT_SAT     = 8'hFF;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] rot_req_s;
  logic [IDX_W-1:0] enc_idx_s;
  logic             enc_any_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             owner_req_s;
  logic             hold_limit_s;

  // Bit ptr is rotated to position 7 so the encoder's top-down search starts there.
  assign rot_req_s = rotl8(req, 3'd7 - ptr_q);

  prio_enc8 u_prio_enc8 (
    .vec (rot_req_s),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  assign win_idx_s    = enc_idx_s + ptr_q + 3'd1;
  assign owner_req_s  = req[owner_q];
  assign hold_limit_s = TIMEOUT_EN && (hold_cnt_q == MAX_HOLD_C);

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc_any_s) begin
          state_d    = BUSY;
          owner_d    = win_idx_s;
          hold_cnt_d = 8'd1;
          gnt_d      = idx_to_onehot(win_idx_s);
          gnt_idx_d  = win_idx_s;
          gnt_vld_d  = 1'b1;
        end else begin
          gnt_d      = 8'h00;
          gnt_idx_d  = 3'd0;
          gnt_vld_d  = 1'b0;
        end
      end

      BUSY: begin
        if (!owner_req_s || hold_limit_s) begin
          // Release and timeout both leave through one idle cycle and rotate priority.
          state_d    = IDLE;
          ptr_d      = owner_q - 3'd1;
          hold_cnt_d = 8'd0;
          gnt_d      = 8'h00;
          gnt_idx_d  = 3'd0;
          gnt_vld_d  = 1'b0;
          timeout_d  = owner_req_s;
        end else begin
          if (hold_cnt_q != CNT_SAT) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        hold_cnt_d = 8'd0;
        gnt_d      = 8'h00;
        gnt_idx_d  = 3'd0;
        gnt_vld_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      owner_q    <= 3'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 8'h00;
      gnt_idx_q  <= 3'd0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule
